// File: rtl/iir_inverse.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// iir_inverse
//   Undoes the first-order smoothing filter y(n) = 0.75x(n) + 0.25y(n-1).
//   It recovers x(n) = (4y(n) - y(n-1)) / 3 one sample at a time and uses a
//   bit-serial restoring divide-by-3.
//   The result is saturated to [0, 2^DW-1]. o_clip flags a clamped result.
//
//   Optional build macro: ROUND_EN
//     defined   : the dividend is num+1 when num >= 0 (round to nearest)
//     undefined : the dividend is num (floor)
//
// Ports
//   clk      in   1    clock, rising edge
//   rst      in   1    asynchronous active-high reset
//   i_valid  in   1    upstream sample valid
//   o_ready  out  1    sample can be accepted (IDLE only)
//   i_data   in   DW   filtered sample y(n), unsigned
//   o_valid  out  1    recovered sample valid
//   i_ready  in   1    downstream accepts o_data
//   o_data   out  DW   recovered sample x(n), unsigned, saturated
//   o_clip   out  1    o_data was clamped to 0 or 2^DW-1
//
// State table
//   state | meaning
//   IDLE  | waiting for an upstream sample, o_ready=1
//   CALC  | form num = 4y - y_prev, load the dividend, update y_prev
//   DIV   | DW+2 restoring divide-by-3 steps, MSB first
//   OUT   | hold the result until downstream takes it
// ---------------------------------------------------------------------------
module iir_inverse #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_clip
);

  localparam int QW = DW + 2;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_LOAD = CW'(QW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] y_reg;
  logic [DW-1:0] y_prev;
  logic [QW-1:0] dividend;
  logic [QW-1:0] quot;
  logic [1:0]    rem;
  logic [CW-1:0] cnt;
  logic          clip_lo;

  logic signed [DW+2:0] num;
  logic                 num_neg;
  logic [QW-1:0]        dividend_ld;
  logic [2:0]           r3;
  logic                 q_bit;
  logic [1:0]           rem_nxt;
  logic [QW-1:0]        q_nxt;
  logic                 div_last;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_valid) state_nxt = CALC;
      CALC: state_nxt = DIV;
      DIV:  if (div_last) state_nxt = OUT;
      OUT:  if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  // The handshake uses only the state. o_ready stays low through the
  // OUT->IDLE cycle, so a new sample cannot be accepted on the same edge
  // that the result is taken.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state)
      IDLE: o_ready = 1'b1;
      OUT:  o_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------- numerator ----------------
  // 4*y occupies DW+2 bits. One more bit is the sign of the difference.
  always_comb begin
    num         = signed'({1'b0, y_reg, 2'b00}) - signed'({3'b000, y_prev});
    num_neg     = num[DW+2];
`ifdef ROUND_EN
    // The maximum value is 4*(2^DW-1)+1. It still fits in DW+2 bits.
    dividend_ld = num[QW-1:0] + {{(QW-1){1'b0}}, 1'b1};
`else
    dividend_ld = num[QW-1:0];
`endif
    if (num_neg) dividend_ld = '0;
  end

  // ---------------- one restoring divide step ----------------
  // The remainder is always < 3, so the partial value r3 is at most 5.
  always_comb begin
    r3    = {rem, dividend[QW-1]};
    q_bit = (r3 >= 3'd3);
    case (r3)
      3'd3:    rem_nxt = 2'd0;
      3'd4:    rem_nxt = 2'd1;
      3'd5:    rem_nxt = 2'd2;
      default: rem_nxt = r3[1:0];
    endcase
    q_nxt    = {quot[QW-2:0], q_bit};
    div_last = (cnt == '0);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg    <= '0;
      y_prev   <= '0;
      dividend <= '0;
      quot     <= '0;
      rem      <= '0;
      cnt      <= '0;
      clip_lo  <= 1'b0;
      o_data   <= '0;
      o_clip   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) y_reg <= i_data;
        end
        CALC: begin
          y_prev   <= y_reg;
          dividend <= dividend_ld;
          clip_lo  <= num_neg;
          quot     <= '0;
          rem      <= '0;
          cnt      <= CNT_LOAD;
        end
        DIV: begin
          dividend <= {dividend[QW-2:0], 1'b0};
          quot     <= q_nxt;
          rem      <= rem_nxt;
          cnt      <= cnt - 1'b1;
          if (div_last) begin
            // Use the quotient with the final bit included, so the result
            // appears on the same edge as the last divide step.
            if (q_nxt[QW-1:DW] != 2'b00) begin
              o_data <= '1;
              o_clip <= 1'b1;
            end else begin
              o_data <= q_nxt[DW-1:0];
              o_clip <= clip_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_inverse.sv
`timescale 1ns/1ps
module tb_iir_inverse;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_clip;

  int compared   = 0;
  int mismatched = 0;

  iir_inverse #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_clip  (o_clip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // The task starts at posedge+1 in IDLE and ends at posedge+1 in IDLE.
  // During OUT it holds backpressure for 'hold' cycles and pulses i_valid
  // once while the result is held.
  task automatic send(input string tag, input logic [DW-1:0] y,
                      input logic [DW-1:0] exp_data, input logic exp_clip,
                      input int hold);
    int lat;
    logic [DW-1:0] held;
    check({tag, ":ready_in"}, 16'(o_ready), 16'd1);
    i_data  = y;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_data  = DW'($urandom);
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ":latency"}, 16'(lat), 16'd11);
    check({tag, ":data"}, 16'(o_data), 16'(exp_data));
    check({tag, ":clip"}, 16'(o_clip), 16'(exp_clip));
    held = o_data;
    for (int i = 0; i < hold; i++) begin
      i_valid = (i == 5);
      i_data  = 8'd0;
      @(posedge clk);
      #1;
      check({tag, ":hold_data"}, 16'(o_data), 16'(held));
      check({tag, ":hold_rdy"}, 16'(o_ready), 16'd0);
      check({tag, ":hold_vld"}, 16'(o_valid), 16'd1);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check({tag, ":vld_drop"}, 16'(o_valid), 16'd0);
    check({tag, ":rdy_back"}, 16'(o_ready), 16'd1);
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    do_reset();
    check("rst:valid", 16'(o_valid), 16'd0);
    check("rst:data",  16'(o_data),  16'd0);
    check("rst:clip",  16'(o_clip),  16'd0);
    check("rst:ready", 16'(o_ready), 16'd1);

    // num=300 -> 100. The next num=4*93-75=297 -> 99 (rounding: 298/3 -> 99).
    send("y75", 8'd75, 8'd100, 1'b0, 0);
    send("y93", 8'd93, 8'd99,  1'b0, 0);
    // num=800-93=707 -> 235 (rounding: 708/3=236).
`ifdef ROUND_EN
    send("y200", 8'd200, 8'd236, 1'b0, 0);
`else
    send("y200", 8'd200, 8'd235, 1'b0, 0);
`endif
    // num=40-200 < 0 -> clamp low.
    send("neg", 8'd10, 8'd0, 1'b1, 0);

    // num=1020 -> 340 -> clamp high.
    do_reset();
    send("sat", 8'd255, 8'd255, 1'b1, 0);

    // Backpressure case. The ignored i_valid pulse must not move y_prev
    // away from 75, so the follow-up sample gives 99.
    do_reset();
    send("bp", 8'd75, 8'd100, 1'b0, 20);
    send("bp_next", 8'd93, 8'd99, 1'b0, 0);

    // Assert reset in the 5th DIV cycle. This drops the sample and clears
    // y_prev, so y=75 gives 100 again (it would give 80 if y_prev were 60).
    i_data  = 8'd60;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst:valid", 16'(o_valid), 16'd0);
    check("midrst:data",  16'(o_data),  16'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst:ready", 16'(o_ready), 16'd1);
    send("midrst_y75", 8'd75, 8'd100, 1'b0, 0);

    // Rounding vs floor: y=2 gives num=8, and y=1 gives num=4 (both after reset).
    do_reset();
`ifdef ROUND_EN
    send("y2", 8'd2, 8'd3, 1'b0, 0);
`else
    send("y2", 8'd2, 8'd2, 1'b0, 0);
`endif
    do_reset();
    send("y1", 8'd1, 8'd1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
